// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction memory read by the fetch stage.
// Accepts a byte stream over a valid/ready handshake, assembles little-endian
// 32-bit words and writes them to consecutive word addresses starting at 0.
// The core is held (core_hold, which gates PC_enable) until the image is in.
//
// Stream: 4-byte little-endian word count N, then N words of 4 bytes each,
// least-significant byte first.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a 4-byte little-endian checksum (mod-2^32 sum of all N
//   words, 0 for N==0) follows the data; a mismatch ends the load in ERR.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   start         single-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_valid      stream byte present
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   imem_we       instruction memory write strobe, one cycle per word
//   imem_addr     word address of the write
//   imem_wdata    word to write
//   core_hold     keeps the core's PC frozen while high
//   busy          a load is in progress
//   done          last load completed successfully
//   error         last load was aborted
//   words_written words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  // Largest legal word count: the whole memory.
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_t          state;
  logic [1:0]      byte_idx;   // wraps 3 -> 0 at each word boundary
  logic [23:0]     byte_buf;   // bytes 0..2 of the word being assembled
  logic [ADDR_W:0] n_words;    // header count, already bounded to MAX_WORDS
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]     csum;
`endif

  logic            take;
  logic            last_byte;
  logic [31:0]     full_word;
  logic [ADDR_W:0] ww_next;

  assign take      = in_valid & in_ready;
  assign last_byte = take & (byte_idx == 2'd3);
  // The 4th byte is used straight from the input, so no 32-bit buffer is kept.
  assign full_word = {in_data, byte_buf};
  assign ww_next   = words_written + (ADDR_W+1)'(1);

  // NOTE: every register here is written with <= so all of them see the
  // pre-edge values of each other; mixing in = would make the result depend
  // on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      byte_idx      <= 2'd0;
      byte_buf      <= '0;
      n_words       <= '0;
      in_ready      <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      core_hold     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      // NOTE: the strobe defaults low every cycle so it is a one-cycle pulse;
      // address and data are only loaded on a write and otherwise hold.
      imem_we <= 1'b0;

      if (take) begin
        byte_idx <= byte_idx + 2'd1;
        unique case (byte_idx)
          2'd0:    byte_buf[7:0]   <= in_data;
          2'd1:    byte_buf[15:8]  <= in_data;
          2'd2:    byte_buf[23:16] <= in_data;
          default: ;
        endcase
      end

      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state         <= S_HDR;
            byte_idx      <= 2'd0;
            words_written <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            in_ready      <= 1'b1;
            busy          <= 1'b1;
            core_hold     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
          end
        end

        S_HDR: begin
          if (last_byte) begin
            if (full_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state     <= S_CSUM;
`else
              state     <= S_DONE;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
              core_hold <= 1'b0;
              done      <= 1'b1;
`endif
            end else if ({1'b0, full_word} > MAX_WORDS) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              state   <= S_DATA;
              n_words <= full_word[ADDR_W:0];
            end
          end
        end

        S_DATA: begin
          if (last_byte) begin
            imem_we       <= 1'b1;
            imem_addr     <= words_written[ADDR_W-1:0];
            imem_wdata    <= full_word;
            words_written <= ww_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= csum + full_word;
`endif
            if (ww_next == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state     <= S_CSUM;
`else
              state     <= S_DONE;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
              core_hold <= 1'b0;
              done      <= 1'b1;
`endif
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (last_byte) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (full_word == csum) begin
              state     <= S_DONE;
              core_hold <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader, built with ADDR_W=4 (16-word memory)
// so the count bounds are reachable. Inputs are driven on the falling edge;
// outputs are sampled on the falling edge. A monitor logs every write with
// the cycle it appeared in, and each load is compared against expected
// status, write list and write latency.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_written;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .core_hold     (core_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  typedef struct {
    logic [31:0] n;
    int          mode;
    bit          exp_done;
    bit          exp_error;
    int          exp_ww;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  int                wr_cyc_q[$];
  int                hs_q[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},      in_ready,      0);
    check({tag, " imem_we"},       imem_we,       0);
    check({tag, " imem_addr"},     imem_addr,     0);
    check({tag, " imem_wdata"},    imem_wdata,    0);
    check({tag, " core_hold"},     core_hold,     1);
    check({tag, " busy"},          busy,          0);
    check({tag, " done"},          done,          0);
    check({tag, " error"},         error,         0);
    check({tag, " words_written"}, words_written, 0);
  endtask

  // Reference outcome from the stream rules: a count up to the memory depth
  // is accepted and every word lands; anything larger aborts after the header.
  function automatic void model(input logic [31:0] n, input bit bad_csum,
                                output bit d, output bit e, output int ww);
    bit accepted;
    accepted = longint'(n) <= longint'(DEPTH);
    d  = accepted && !bad_csum;
    e  = !d;
    ww = accepted ? int'(n) : 0;
  endfunction

  function automatic wq_t make_words(input logic [31:0] n);
    wq_t w;
    if (longint'(n) <= longint'(DEPTH))
      for (int k = 0; k < int'(n); k++) w.push_back($urandom);
    return w;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: valid every other cycle, 2: random gaps.
  task automatic send_stream(input bq_t b, input int mode, input int start_at, output bit ok);
    int  i;
    int  guard;
    bit  v;
    i     = 0;
    guard = 0;
    hs_q.delete();
    while (i < b.size() && guard < 4000) begin
      @(negedge clk);
      case (mode)
        1:       v = (cyc % 2) == 0;
        2:       v = $urandom_range(0, 2) != 0;
        default: v = 1'b1;
      endcase
      in_valid = v;
      in_data  = v ? b[i] : 8'($urandom);
      start    = (start_at >= 0) && (i == start_at);
      if (v && in_ready === 1'b1) begin
        hs_q.push_back(cyc + 1);
        i++;
      end
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    ok = (i == b.size());
  endtask

  // start_at: -1 none, -2 on the final byte, otherwise a byte index.
  task automatic run_load(input string tag, input logic [31:0] n, input wq_t words,
                          input int mode, input int start_at, input bit bad_csum,
                          input bit exp_done, input bit exp_error, input int exp_ww);
    bq_t         b;
    logic [31:0] sum;
    bit          sent;
    int          g;
    int          sa;
    int          n_wr;
    sum = 32'd0;
    for (int j = 0; j < 4; j++) b.push_back(n[8*j +: 8]);
    foreach (words[k]) begin
      for (int j = 0; j < 4; j++) b.push_back(words[k][8*j +: 8]);
      sum = sum + words[k];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (words.size() == int'(n)) begin
      sum = sum + (bad_csum ? 32'd1 : 32'd0);
      for (int j = 0; j < 4; j++) b.push_back(sum[8*j +: 8]);
    end
`endif
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();

    pulse_start();
    check({tag, " start_flags"}, {busy, in_ready, done, error, core_hold}, 5'b11001);
    check({tag, " start_ww"}, words_written, 0);

    sa = (start_at == -2) ? b.size() - 1 : start_at;
    send_stream(b, mode, sa, sent);
    check({tag, " stream_accepted"}, sent, 1);

    g = 0;
    while (busy !== 1'b0 && g < 64) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);

    check({tag, " busy"},          busy,          0);
    check({tag, " in_ready"},      in_ready,      0);
    check({tag, " done"},          done,          exp_done);
    check({tag, " error"},         error,         exp_error);
    check({tag, " core_hold"},     core_hold,     !exp_done);
    check({tag, " words_written"}, words_written, exp_ww);
    n_wr = wr_addr_q.size();
    check({tag, " write_count"}, n_wr, exp_ww);
    for (int k = 0; k < n_wr && k < words.size(); k++) begin
      check({tag, " write_addr_data"}, {28'(wr_addr_q[k]), wr_data_q[k]}, {28'(k), words[k]});
      if (4 + 4*k + 3 < hs_q.size())
        check({tag, " write_latency"}, wr_cyc_q[k], hs_q[4 + 4*k + 3]);
    end
  endtask

  initial begin
    vec_t        vecs[7];
    wq_t         w;
    bq_t         b;
    bit          sent;
    bit          d;
    bit          e;
    int          ww;
    logic [31:0] n;
    bit          bad;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Bytes offered while idle must be ignored.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    check("idle_valid in_ready", in_ready, 0);
    check("idle_valid busy", busy, 0);
    in_valid = 1'b0;

    // Stream 01 00 00 00 13 00 00 00.
    w = '{32'h0000_0013};
    run_load("one_word", 32'd1, w, 0, -1, 1'b0, 1'b1, 1'b0, 1);

    // N=3 with valid toggling every other cycle.
    w = '{32'h0050_0093, 32'h00A0_0113, 32'h0000_0073};
    run_load("three_toggle", 32'd3, w, 1, -1, 1'b0, 1'b1, 1'b0, 3);

    vecs = '{
      '{32'd0,          0, 1'b1, 1'b0, 0},
      '{32'd1,          1, 1'b1, 1'b0, 1},
      '{32'd16,         0, 1'b1, 1'b0, 16},
      '{32'd17,         0, 1'b0, 1'b1, 0},
      '{32'h0001_0000,  2, 1'b0, 1'b1, 0},
      '{32'h0100_0001,  0, 1'b0, 1'b1, 0},
      '{32'hFFFF_FFFF,  2, 1'b0, 1'b1, 0}
    };
    foreach (vecs[i]) begin
      w = make_words(vecs[i].n);
      run_load($sformatf("vec%0d", i), vecs[i].n, w, vecs[i].mode, -1, 1'b0,
               vecs[i].exp_done, vecs[i].exp_error, vecs[i].exp_ww);
    end

    // start while loading data is ignored.
    w = '{32'hDEAD_BEEF, 32'h1234_5678};
    run_load("start_mid", 32'd2, w, 0, 6, 1'b0, 1'b1, 1'b0, 2);

    // start coinciding with the final byte is ignored.
    w = '{32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
    run_load("start_last", 32'd3, w, 2, -2, 1'b0, 1'b1, 1'b0, 3);

    // Reset in the middle of DATA after 5 bytes, then a fresh load.
    pulse_start();
    b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA};
    send_stream(b, 0, -1, sent);
    check("rst_mid busy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    w = '{32'h0000_1111, 32'h0000_2222};
    run_load("after_rst", 32'd2, w, 0, -1, 1'b0, 1'b1, 1'b0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    w = '{32'd1, 32'd2};
    run_load("csum_good", 32'd2, w, 0, -1, 1'b0, 1'b1, 1'b0, 2);
    run_load("csum_bad",  32'd2, w, 0, -1, 1'b1, 1'b0, 1'b1, 2);
`endif

    for (int r = 0; r < 25; r++) begin
      n   = 32'($urandom_range(0, DEPTH + 2));
      bad = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      bad = $urandom_range(0, 3) == 0;
`endif
      w = make_words(n);
      model(n, bad, d, e, ww);
      run_load($sformatf("rand%0d", r), n, w, $urandom_range(0, 2), -1, bad, d, e, ww);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
